reflet_wb_bridge: RTL and testbench

Bridges the CPU's memory port (address, write data, write strobe, read data) onto a Wishbone classic master bus. The CPU core side expects zero-wait-state memory. The bridge satisfies that expectation with a single-entry read buffer and stalls the core through `cpu_enable` whenever a bus transaction is outstanding. It sits directly downstream of the address/alignment stage and replaces the direct RAM connection when memory or peripherals have variable latency.

---
 rtl/reflet_wb_bridge_pkg.sv | 16 +
 rtl/reflet_bus_timer.sv | 30 +++
 rtl/reflet_wb_bridge.sv | 115 +++++++++++
 tb/tb_reflet_wb_bridge.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflet_wb_bridge_pkg.sv
// Shared types for the reflet Wishbone bridge.
// Bus-master state encoding and small helpers.
package reflet_wb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WDONE = 2'd3
  } bridge_state_t;

  function automatic logic is_busy(bridge_state_t s);
    return (s == ST_READ) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/reflet_bus_timer.sv
// Wait-state counter for one bus transfer.
// Loads 1 on start so the first STB cycle counts as cycle 1.
module reflet_bus_timer #(
  parameter int timeout_cycles = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic done,
  output logic expired
);

  localparam int CW = $clog2(timeout_cycles + 1);
  localparam logic [CW-1:0] LIMIT = CW'(timeout_cycles);

  logic [CW-1:0] count;

  // Count bus cycles of the current transfer, saturating at the limit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (start)
      count <= CW'(1);
    else if (!done && count != LIMIT)
      count <= count + CW'(1);
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/reflet_wb_bridge.sv
// CPU memory port to Wishbone classic master.
// Single-entry read buffer; stalls the core while the bus is busy.
module reflet_wb_bridge
  import reflet_wb_bridge_pkg::*;
#(
  parameter int wordsize       = 16,
  parameter int timeout_cycles = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                cpu_enable,
  input  logic                invalidate,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [wordsize-1:0] wb_adr_o,
  output logic [wordsize-1:0] wb_dat_o,
  input  logic [wordsize-1:0] wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                bus_error
);

  bridge_state_t state, next_state;

  logic [wordsize-1:0] tag_addr;
  logic [wordsize-1:0] data_reg;
  logic                tag_valid;
  logic                hit;
  logic                start;
  logic                done;
  logic                expired;
  logic                abort;
  logic                term;

  assign hit   = tag_valid && (cpu_addr == tag_addr);
  assign start = (state == ST_IDLE) && (cpu_write_en || !hit);
  assign abort = is_busy(state) && (wb_err_i || expired);
  assign term  = is_busy(state) && (wb_ack_i || abort);
  assign done  = !is_busy(state) || term;

  assign cpu_data_in = data_reg;

  reflet_bus_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .done   (done),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: begin
        if (cpu_write_en) next_state = ST_WRITE;
        else if (!hit)    next_state = ST_READ;
      end
      ST_READ:  if (term) next_state = ST_IDLE;
      ST_WRITE: if (term) next_state = ST_WDONE;
      ST_WDONE: next_state = ST_IDLE;
    endcase
  end

  // Bus strobes and core enable decoded from state.
  always_comb begin
    wb_cyc_o   = is_busy(state);
    wb_stb_o   = is_busy(state);
    wb_we_o    = (state == ST_WRITE);
    cpu_enable = (state == ST_WDONE) ||
                 ((state == ST_IDLE) && hit && !cpu_write_en);
  end

  // Bus address/data latch, read buffer and error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      tag_addr  <= '0;
      tag_valid <= 1'b0;
      data_reg  <= '0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= abort;
      if (start) begin
        wb_adr_o <= cpu_addr;
        if (cpu_write_en) wb_dat_o <= cpu_data_out;
      end
      if (state == ST_READ && term) begin
        tag_addr  <= wb_adr_o;
        tag_valid <= 1'b1;
        data_reg  <= abort ? '0 : wb_dat_i;
      end else begin
        if (invalidate) tag_valid <= 1'b0;
        if (state == ST_WRITE && term && !abort &&
            wb_adr_o == tag_addr)
          data_reg <= wb_dat_o;
      end
    end
  end

endmodule

// File: tb/tb_reflet_wb_bridge.sv
// Directed self-checking bench for reflet_wb_bridge.
// Second instance uses a short timeout for the abort path.
module tb_reflet_wb_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr, cpu_data_out, cpu_data_in;
  logic        cpu_write_en, cpu_enable, invalidate;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i, wb_err_i, bus_error;

  logic        t_reset;
  logic [15:0] t_addr, t_data_in, t_adr, t_dat;
  logic        t_en, t_cyc, t_stb, t_we, t_berr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reflet_wb_bridge dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_write_en(cpu_write_en), .cpu_data_in(cpu_data_in),
    .cpu_enable(cpu_enable), .invalidate(invalidate),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .bus_error(bus_error)
  );

  reflet_wb_bridge #(.wordsize(16), .timeout_cycles(4)) dut_to (
    .clk(clk), .reset(t_reset),
    .cpu_addr(t_addr), .cpu_data_out(16'h0000),
    .cpu_write_en(1'b0), .cpu_data_in(t_data_in),
    .cpu_enable(t_en), .invalidate(1'b0),
    .wb_cyc_o(t_cyc), .wb_stb_o(t_stb), .wb_we_o(t_we),
    .wb_adr_o(t_adr), .wb_dat_o(t_dat), .wb_dat_i(16'hDEAD),
    .wb_ack_i(1'b0), .wb_err_i(1'b0), .bus_error(t_berr)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; t_reset = 1'b1;
    cpu_addr = 16'h0; cpu_data_out = 16'h0;
    cpu_write_en = 1'b0; invalidate = 1'b0;
    wb_dat_i = 16'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    t_addr = 16'h0;
    tick; tick;
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, bus_error, cpu_enable} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_ctrl: got %b want 00000",
        {wb_cyc_o, wb_stb_o, wb_we_o, bus_error, cpu_enable});
    end
    n_cmp++;
    if ({wb_adr_o, wb_dat_o, cpu_data_in} !== 48'h0) begin
      n_err++;
      $display("FAIL rst_data: got %h %h %h want 0 0 0",
        wb_adr_o, wb_dat_o, cpu_data_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_read_miss;
    cpu_addr = 16'h0010;
    #1;
    n_cmp++;
    if (cpu_enable !== 1'b0 || wb_stb_o !== 1'b0) begin
      n_err++;
      $display("FAIL rd_c0: got en=%b stb=%b want 0 0",
        cpu_enable, wb_stb_o);
    end
    tick;
    wb_dat_i = 16'hBEEF; wb_ack_i = 1'b1;
    #1;
    n_cmp++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, cpu_enable} !== 4'b1100 ||
        wb_adr_o !== 16'h0010) begin
      n_err++;
      $display("FAIL rd_c1: got cyc/stb/we/en=%b adr=%h want 1100 0010",
        {wb_cyc_o, wb_stb_o, wb_we_o, cpu_enable}, wb_adr_o);
    end
    tick;
    wb_ack_i = 1'b0; wb_dat_i = 16'h0;
    #1;
    n_cmp++;
    if (cpu_enable !== 1'b1 || cpu_data_in !== 16'hBEEF ||
        wb_stb_o !== 1'b0) begin
      n_err++;
      $display("FAIL rd_c2: got en=%b data=%h stb=%b want 1 beef 0",
        cpu_enable, cpu_data_in, wb_stb_o);
    end
    tick;
    n_cmp++;
    if (cpu_enable !== 1'b1 || wb_cyc_o !== 1'b0) begin
      n_err++;
      $display("FAIL rd_hit: got en=%b cyc=%b want 1 0",
        cpu_enable, wb_cyc_o);
    end
  endtask

  task automatic test_write_waits;
    int stb_cnt;
    int en_cnt;
    stb_cnt = 0; en_cnt = 0;
    cpu_addr = 16'h0010; cpu_data_out = 16'h1234; cpu_write_en = 1'b1;
    #1;
    if (cpu_enable) en_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick;
      wb_ack_i = (i == 3);
      #1;
      if (wb_stb_o) stb_cnt++;
      if (cpu_enable) en_cnt++;
      n_cmp++;
      if (wb_stb_o !== 1'b1 || wb_we_o !== 1'b1 ||
          wb_dat_o !== 16'h1234) begin
        n_err++;
        $display("FAIL wr_stb%0d: got stb=%b we=%b dat=%h want 1 1 1234",
          i, wb_stb_o, wb_we_o, wb_dat_o);
      end
    end
    tick;
    wb_ack_i = 1'b0;
    #1;
    if (cpu_enable) en_cnt++;
    n_cmp++;
    if (cpu_enable !== 1'b1 || wb_stb_o !== 1'b0) begin
      n_err++;
      $display("FAIL wr_wdone: got en=%b stb=%b want 1 0",
        cpu_enable, wb_stb_o);
    end
    cpu_write_en = 1'b0;
    n_cmp++;
    if (stb_cnt !== 4 || en_cnt !== 1) begin
      n_err++;
      $display("FAIL wr_counts: got stb=%0d en=%0d want 4 1",
        stb_cnt, en_cnt);
    end
    tick;
    n_cmp++;
    if (cpu_enable !== 1'b1 || cpu_data_in !== 16'h1234 ||
        wb_cyc_o !== 1'b0) begin
      n_err++;
      $display("FAIL wr_readback: got en=%b data=%h cyc=%b want 1 1234 0",
        cpu_enable, cpu_data_in, wb_cyc_o);
    end
  endtask

  task automatic test_err_ack;
    cpu_addr = 16'h0020;
    tick;
    wb_dat_i = 16'h5555; wb_ack_i = 1'b1; wb_err_i = 1'b1;
    #1;
    n_cmp++;
    if (wb_stb_o !== 1'b1 || wb_we_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_stb: got stb=%b we=%b want 1 0",
        wb_stb_o, wb_we_o);
    end
    tick;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 16'h0;
    #1;
    n_cmp++;
    if (bus_error !== 1'b1 || cpu_data_in !== 16'h0000 ||
        cpu_enable !== 1'b1) begin
      n_err++;
      $display("FAIL err_path: got berr=%b data=%h en=%b want 1 0000 1",
        bus_error, cpu_data_in, cpu_enable);
    end
    tick;
    n_cmp++;
    if (bus_error !== 1'b0) begin
      n_err++;
      $display("FAIL err_pulse: got berr=%b want 0", bus_error);
    end
  endtask

  task automatic test_invalidate;
    cpu_addr = 16'h0010;
    tick;
    wb_dat_i = 16'hCAFE; wb_ack_i = 1'b1;
    tick;
    wb_ack_i = 1'b0;
    #1;
    n_cmp++;
    if (cpu_enable !== 1'b1 || cpu_data_in !== 16'hCAFE) begin
      n_err++;
      $display("FAIL inv_fill: got en=%b data=%h want 1 cafe",
        cpu_enable, cpu_data_in);
    end
    invalidate = 1'b1;
    tick;
    invalidate = 1'b0;
    #1;
    n_cmp++;
    if (cpu_enable !== 1'b0 || wb_stb_o !== 1'b0) begin
      n_err++;
      $display("FAIL inv_miss: got en=%b stb=%b want 0 0",
        cpu_enable, wb_stb_o);
    end
    tick;
    n_cmp++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 16'h0010) begin
      n_err++;
      $display("FAIL inv_reread: got stb=%b adr=%h want 1 0010",
        wb_stb_o, wb_adr_o);
    end
    wb_ack_i = 1'b1;
    tick;
    wb_ack_i = 1'b0;
    wb_dat_i = 16'h0;
  endtask

  task automatic test_reset_mid;
    cpu_addr = 16'h0030;
    tick;
    n_cmp++;
    if (wb_stb_o !== 1'b1) begin
      n_err++;
      $display("FAIL rm_stb: got stb=%b want 1", wb_stb_o);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || bus_error !== 1'b0) begin
      n_err++;
      $display("FAIL rm_drop: got cyc=%b stb=%b berr=%b want 0 0 0",
        wb_cyc_o, wb_stb_o, bus_error);
    end
    tick;
    reset = 1'b0;
    cpu_addr = 16'h0000;
    #1;
    n_cmp++;
    if (cpu_enable !== 1'b0 || wb_stb_o !== 1'b0 ||
        cpu_data_in !== 16'h0000) begin
      n_err++;
      $display("FAIL rm_after: got en=%b stb=%b data=%h want 0 0 0000",
        cpu_enable, wb_stb_o, cpu_data_in);
    end
  endtask

  task automatic test_timeout;
    t_addr = 16'h0010;
    t_reset = 1'b0;
    #1;
    n_cmp++;
    if (t_en !== 1'b0 || t_stb !== 1'b0) begin
      n_err++;
      $display("FAIL to_c0: got en=%b stb=%b want 0 0", t_en, t_stb);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      n_cmp++;
      if ({t_cyc, t_stb, t_we, t_berr} !== 4'b1100 ||
          t_adr !== 16'h0010) begin
        n_err++;
        $display("FAIL to_stb%0d: got cyc/stb/we/berr=%b adr=%h want 1100 0010",
          i, {t_cyc, t_stb, t_we, t_berr}, t_adr);
      end
    end
    tick;
    n_cmp++;
    if (t_stb !== 1'b0 || t_berr !== 1'b1 || t_data_in !== 16'h0000 ||
        t_dat !== 16'h0000) begin
      n_err++;
      $display("FAIL to_abort: got stb=%b berr=%b data=%h dat=%h want 0 1 0000 0000",
        t_stb, t_berr, t_data_in, t_dat);
    end
    tick;
    n_cmp++;
    if (t_en !== 1'b1 || t_berr !== 1'b0) begin
      n_err++;
      $display("FAIL to_resume: got en=%b berr=%b want 1 0", t_en, t_berr);
    end
  endtask

  initial begin
    test_reset;
    test_read_miss;
    test_write_waits;
    test_err_ack;
    test_invalidate;
    test_reset_mid;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
